// File: rtl/rv_mem_arb_if.sv
// Bus bundle between the two requesters (LSU, IFU), the arbiter and the RAM port.
// The arbiter uses the slave modport; requesters and the RAM side use master.
interface rv_mem_arb_if #(
  parameter int XLEN = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [XLEN/8-1:0] m0_be_i;
  logic [XLEN-1:0]   m0_addr_i;
  logic [XLEN-1:0]   m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [XLEN-1:0]   m0_rdata_o;
  logic              m0_err_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [XLEN/8-1:0] m1_be_i;
  logic [XLEN-1:0]   m1_addr_i;
  logic [XLEN-1:0]   m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [XLEN-1:0]   m1_rdata_o;
  logic              m1_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/rv_mem_arb.sv
// Two-master arbiter for the rv_ram data port with per-transaction watchdog.
// Define RV_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (m0 wins).
module rv_mem_arb #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  rv_mem_arb_if.slave     bus
);
  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_owner;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [BW-1:0]           r_mem_be;
  logic [XLEN-1:0]         r_mem_addr;
  logic [XLEN-1:0]         r_mem_wdata;
  logic [1:0]              r_rvalid;
  logic [1:0]              r_err;
  logic [1:0][XLEN-1:0]    r_rdata;

  logic [1:0]              w_req;
  logic [1:0]              w_we;
  logic [1:0][BW-1:0]      w_be;
  logic [1:0][XLEN-1:0]    w_addr;
  logic [1:0][XLEN-1:0]    w_wdata;
  logic                    w_sel;
  logic                    w_gnt_en;
  logic [1:0]              w_gnt;

  assign w_req   = {bus.m1_req_i, bus.m0_req_i};
  assign w_we    = {bus.m1_we_i, bus.m0_we_i};
  assign w_be    = {bus.m1_be_i, bus.m0_be_i};
  assign w_addr  = {bus.m1_addr_i, bus.m0_addr_i};
  assign w_wdata = {bus.m1_wdata_i, bus.m0_wdata_i};

`ifdef RV_ARB_RR_EN
  logic r_last;
  // On a tie, prefer whichever master did not win last time.
  assign w_sel = w_req[1] & (~w_req[0] | ~r_last);
`else
  assign w_sel = w_req[1] & ~w_req[0];
`endif

  // Grant is only ever offered from IDLE, and never while reset is applied.
  assign w_gnt_en = (r_state == IDLE) && (|w_req) && arstn_i;
  assign w_gnt[0] = w_gnt_en & ~w_sel;
  assign w_gnt[1] = w_gnt_en &  w_sel;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid    <= '0;
      r_err       <= '0;
      r_rdata     <= '0;
`ifdef RV_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_rvalid <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_owner     <= w_sel;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_we[w_sel];
            r_mem_be    <= w_be[w_sel];
            r_mem_addr  <= w_addr[w_sel];
            r_mem_wdata <= w_wdata[w_sel];
            r_cnt       <= '0;
            r_state     <= BUSY;
`ifdef RV_ARB_RR_EN
            r_last      <= w_sel;
`endif
          end
        end
        BUSY: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
          if (bus.mem_rvalid_i) begin
            r_rvalid[r_owner] <= 1'b1;
            // Write completions report zero data.
            r_rdata[r_owner]  <= r_mem_we ? '0 : bus.mem_rdata_i;
            r_mem_req         <= 1'b0;
            r_state           <= RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            r_rvalid[r_owner] <= 1'b1;
            r_err[r_owner]    <= 1'b1;
            r_mem_req         <= 1'b0;
            r_state           <= RELEASE;
          end
        end
        RELEASE: begin
          // One idle cycle with mem_req low so the RAM flushes its latency chain.
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m0_gnt_o    = w_gnt[0];
  assign bus.m1_gnt_o    = w_gnt[1];
  assign bus.m0_rvalid_o = r_rvalid[0];
  assign bus.m1_rvalid_o = r_rvalid[1];
  assign bus.m0_rdata_o  = r_rdata[0];
  assign bus.m1_rdata_o  = r_rdata[1];
  assign bus.m0_err_o    = r_err[0];
  assign bus.m1_err_o    = r_err[1];

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_be_o    = r_mem_be;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb with a latency-3 RAM stub and a 16-cycle watchdog.
module tb_rv_mem_arb;
  localparam int L = 3;
`ifdef RV_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic arstn = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  rv_mem_arb_if #(.XLEN(32)) bus ();

  rv_mem_arb #(.XLEN(32), .TIMEOUT(16)) u_dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM stub: fixed-latency chain cleared whenever mem_req drops.
  logic [31:0] mem [0:63];
  logic [L:0]  sr;
  bit          never_rv = 1'b0;
  bit          hold_hi  = 1'b0;

  always_ff @(posedge clk) begin
    if (!bus.mem_req_o) sr <= '0;
    else                sr <= {sr[L-1:0], 1'b1};
    if (bus.mem_req_o && bus.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be_o[b]) mem[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
    end
  end

  assign bus.mem_rvalid_i = never_rv ? 1'b0 : ((hold_hi && !bus.mem_req_o) ? 1'b1 : sr[L]);
  assign bus.mem_rdata_i  = mem[bus.mem_addr_o[7:2]];

  logic [1:0]  gnt_v, rv_v, err_v;
  logic [31:0] rd_v [2];
  assign gnt_v = {bus.m1_gnt_o, bus.m0_gnt_o};
  assign rv_v  = {bus.m1_rvalid_o, bus.m0_rvalid_o};
  assign err_v = {bus.m1_err_o, bus.m0_err_o};
  assign rd_v[0] = bus.m0_rdata_o;
  assign rd_v[1] = bus.m1_rdata_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int m, input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_be_i = be;
      bus.m0_addr_i = addr; bus.m0_wdata_i = wdata;
    end else begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_be_i = be;
      bus.m1_addr_i = addr; bus.m1_wdata_i = wdata;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt_v}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, rv_v}, 32'd0);
    chk({tag, "_err"}, {30'd0, err_v}, 32'd0);
    chk({tag, "_rdata0"}, rd_v[0], 32'd0);
    chk({tag, "_rdata1"}, rd_v[1], 32'd0);
    chk({tag, "_mem_req"}, {31'd0, bus.mem_req_o}, 32'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata_o, 32'd0);
    chk({tag, "_mem_webe"}, {27'd0, bus.mem_we_o, bus.mem_be_o}, 32'd0);
  endtask

  task automatic run_txn(input string tag, input int m, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit exp_err, input int exp_lat);
    int  gcyc = 0;
    int  dcyc = -1;
    int  other_bad = 0;
    int  extra = 0;
    bit  got = 1'b0;
    @(posedge clk); #1;
    drive(m, 1'b1, we, be, addr, wdata);
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (gnt_v[m]) begin
        got = 1'b1;
        gcyc = cyc;
        chk({tag, "_gnt_other"}, {31'd0, gnt_v[1-m]}, 32'd0);
      end
    end
    chk({tag, "_gnt"}, {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    if (!got) return;
    for (int k = 0; k < 40 && dcyc < 0; k++) begin
      @(negedge clk);
      if (cyc == gcyc + 1) begin
        chk({tag, "_mem_req"}, {31'd0, bus.mem_req_o}, 32'd1);
        chk({tag, "_mem_addr"}, bus.mem_addr_o, addr);
        chk({tag, "_mem_webe"}, {27'd0, bus.mem_we_o, bus.mem_be_o}, {27'd0, we, be});
      end
      if (rv_v[1-m] || err_v[1-m] || rd_v[1-m] != 32'd0) other_bad++;
      if (rv_v[m]) begin
        dcyc = cyc;
        chk({tag, "_rdata"}, rd_v[m], exp_rd);
        chk({tag, "_err"}, {31'd0, err_v[m]}, {31'd0, exp_err});
      end
    end
    chk({tag, "_latency"}, dcyc - gcyc, exp_lat);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rv_v != 2'b00) extra++;
    end
    chk({tag, "_extra_rvalid"}, extra, 0);
    chk({tag, "_other_quiet"}, other_bad, 0);
    $display("txn %s: m%0d addr=%h lat=%0d rdata=%h err=%0d", tag, m, addr, dcyc - gcyc,
             rd_v[m], err_v[m]);
  endtask

  initial begin
    int ng;
    int prev;
    int exp_m;
    int spur;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'hDEADBEEF;
    mem[32'h20 >> 2] = 32'hAABBCCDD;
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);

    #2 arstn = 1'b0;
    #20;
    check_all_zero("reset");
    $display("reset check done");
    @(negedge clk) arstn = 1'b1;

    run_txn("rd_m0", 0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6);
    run_txn("wr_m1", 1, 1'b1, 4'b0101, 32'h20, 32'h11223344, 32'h0, 1'b0, 6);
    run_txn("rd_back", 0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0, 6);

    // Contention: last winner was m0, so round-robin hands the first tie to m1.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    ng = 0; prev = 0;
    exp_m = RR ? 1 : 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      @(negedge clk);
      if (gnt_v != 2'b00) begin
        chk("tie_one_gnt", $countones(gnt_v), 1);
        chk("tie_winner", {31'd0, gnt_v[1]}, exp_m);
        if (ng > 0) chk("tie_spacing", cyc - prev, 7);
        $display("tie grant %0d: gnt=%b cycle=%0d", ng, gnt_v, cyc);
        prev = cyc;
        ng++;
        if (RR) exp_m = 1 - exp_m;
      end
    end
    chk("tie_count", ng, 4);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (12) @(negedge clk);

    never_rv = 1'b1;
    run_txn("timeout", 0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b1, 17);
    never_rv = 1'b0;
    run_txn("after_to", 0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6);

    hold_hi = 1'b1;
    spur = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv_v != 2'b00 || err_v != 2'b00) spur++;
    end
    chk("hold_idle_spurious", spur, 0);
    run_txn("hold_rd_m1", 1, 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6);
    hold_hi = 1'b0;

    // Reset while BUSY: outputs clear at once and the transaction vanishes.
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk);
    chk("rst_busy_gnt", {31'd0, gnt_v[0]}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #3;
    chk("rst_busy_pre", {31'd0, bus.mem_req_o}, 32'd1);
    arstn = 1'b0;
    #1;
    check_all_zero("rst_busy");
    @(negedge clk) arstn = 1'b1;
    spur = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rv_v != 2'b00 || bus.mem_req_o) spur++;
    end
    chk("rst_busy_dropped", spur, 0);
    run_txn("post_rst", 0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22CC44, 1'b0, 6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "bench timeout");
  end
endmodule
